vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_axis_counter.sv | 74 +++++++
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA timing path.
//   - VGA_H_* / VGA_V_* : 800x600@60 Hz (40 MHz pixel clock) timing, used as
//                         parameter defaults by vga_timing_gen
//   - X_W / Y_W          : coordinate widths
//   - vga_coord_t        : {x,y} pixel coordinate for downstream pixel logic
//   - axis_total()       : total length of one axis from its four segments
package vga_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } vga_coord_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Wraps 0..TOTAL-1 and decodes the active
// and sync windows of the value it is about to hold, so the parent can
// register those decodes alongside the count.
//   clk_i      : clock
//   srst_i     : synchronous reset, active-high (count -> 0)
//   inc_i      : advance by one this cycle
//   count_o    : current count (registered)
//   count_d_o  : count after this edge
//   active_d_o : count_d_o inside the active window
//   sync_d_o   : sync level for count_d_o (POL when inside the sync window)
//   wrap_o     : this edge wraps TOTAL-1 -> 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE = 800,
  parameter int   FP     = 40,
  parameter int   SYNC   = 128,
  parameter int   BP     = 88,
  parameter logic POL    = 1'b1,
  parameter int   W      = 11
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_d_o,
  output logic         active_d_o,
  output logic         sync_d_o,
  output logic         wrap_o
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  // Window bounds carry one extra bit so a sync window ending exactly at
  // 2**W still compares correctly.
  localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         wrap_d;
  logic [W:0]   count_ext;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (inc_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_ext  = {1'b0, count_d};
  assign active_d_o = (count_ext < ACT_END);
  assign sync_d_o   = ((count_ext >= SYNC_BEG) && (count_ext < SYNC_END)) ? POL : ~POL;
  assign count_o    = count_q;
  assign count_d_o  = count_d;
  assign wrap_o     = wrap_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 Hz raster timing on the 40 MHz pixel clock.
// Every output is a register; x/y and all decodes describe the same
// presented position in the same cycle.
//   clk_in      : pixel clock
//   rst         : synchronous reset, active-high
//   en          : advance enable; low freezes the raster and blanks de/strobes
//   hsync/vsync : syncs, active level HS_POL / VS_POL
//   de          : presented pixel is visible
//   x, y        : presented column / line
//   line_start  : presented x == 0
//   frame_start : presented (x,y) == (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           en,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << X_W)) begin : g_h_width_check
    $error("vga_timing_gen: H_TOTAL does not fit the x counter");
  end
  if (V_TOTAL > (1 << Y_W)) begin : g_v_width_check
    $error("vga_timing_gen: V_TOTAL does not fit the y counter");
  end

  // live_q is set once the counters hold a position that has already been
  // presented while enabled. Until then (after reset or an en=0 cycle) the
  // next enabled edge presents the held position instead of advancing.
  logic live_q;

  logic           h_inc;
  logic [X_W-1:0] h_count;
  logic [X_W-1:0] h_count_d;
  logic           h_active_d;
  logic           h_sync_d;
  logic           h_wrap;

  logic           v_inc;
  logic [Y_W-1:0] v_count;
  logic [Y_W-1:0] v_count_d;
  logic           v_active_d;
  logic           v_sync_d;
  // The frame restart is visible as v_count_d == 0; the wrap pulse itself
  // has no consumer.
  logic           unused_v_wrap;

  logic de_q;
  logic line_start_q;
  logic frame_start_q;
  logic hsync_q;
  logic vsync_q;

  vga_coord_t pos;

  assign h_inc = en & live_q;
  assign v_inc = h_wrap & en;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (X_W)
  ) u_h_axis (
    .clk_i      (clk_in),
    .srst_i     (rst),
    .inc_i      (h_inc),
    .count_o    (h_count),
    .count_d_o  (h_count_d),
    .active_d_o (h_active_d),
    .sync_d_o   (h_sync_d),
    .wrap_o     (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (Y_W)
  ) u_v_axis (
    .clk_i      (clk_in),
    .srst_i     (rst),
    .inc_i      (v_inc),
    .count_o    (v_count),
    .count_d_o  (v_count_d),
    .active_d_o (v_active_d),
    .sync_d_o   (v_sync_d),
    .wrap_o     (unused_v_wrap)
  );

  // Decodes are taken from the counters' next values so they land in the
  // same edge as the position they describe.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      live_q        <= 1'b0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
    end else begin
      live_q <= en;
      if (en) begin
        de_q          <= h_active_d & v_active_d;
        line_start_q  <= (h_count_d == '0);
        frame_start_q <= (h_count_d == '0) && (v_count_d == '0);
        hsync_q       <= h_sync_d;
        vsync_q       <= v_sync_d;
      end else begin
        de_q          <= 1'b0;
        line_start_q  <= 1'b0;
        frame_start_q <= 1'b0;
      end
    end
  end

  // The counters only move on enabled edges, so their registers are exactly
  // the presented position.
  assign pos         = '{x: h_count, y: v_count};
  assign x           = pos.x;
  assign y           = pos.y;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Horizontal timing is the 800x600 default; the
// vertical axis is shortened to 12 visible lines (FP 1, sync 4, BP 3,
// total 20) so complete frames fit a short run. Position is modelled as a
// linear index into the frame; x/y and all decodes are derived from it.
module tb_vga_timing_gen;

  localparam int HT     = 1056;
  localparam int VA     = 12;
  localparam int VT     = 20;
  localparam int FRAME  = HT * VT;   // 21120

  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic        en     = 1'b0;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [10:0] x;
  logic [9:0]  y;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  vga_timing_gen #(
    .V_ACTIVE (VA),
    .V_FP     (1),
    .V_SYNC   (4),
    .V_BP     (3)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  function automatic int nxt(input int p, input bit live);
    return live ? (p + 1) % FRAME : p;
  endfunction
  function automatic bit f_de(input int p);
    return ((p % HT) < 800) && ((p / HT) < VA);
  endfunction
  function automatic bit f_hs(input int p);
    return ((p % HT) >= 840) && ((p % HT) < 968);
  endfunction
  function automatic bit f_vs(input int p);
    return ((p / HT) >= 13) && ((p / HT) < 17);
  endfunction

  int m_pos  = 0;
  bit m_live = 1'b0;   // last edge was enabled and out of reset
  bit m_de = 0, m_ls = 0, m_fs = 0, m_hs = 0, m_vs = 0;

  always @(posedge clk_in) begin
    if (rst) begin
      m_pos <= 0; m_live <= 1'b0;
      m_de <= 0; m_ls <= 0; m_fs <= 0; m_hs <= 0; m_vs <= 0;
    end else if (en) begin
      m_pos  <= nxt(m_pos, m_live);
      m_live <= 1'b1;
      m_de   <= f_de(nxt(m_pos, m_live));
      m_ls   <= (nxt(m_pos, m_live) % HT) == 0;
      m_fs   <= nxt(m_pos, m_live) == 0;
      m_hs   <= f_hs(nxt(m_pos, m_live));
      m_vs   <= f_vs(nxt(m_pos, m_live));
    end else begin
      m_live <= 1'b0;
      m_de <= 0; m_ls <= 0; m_fs <= 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_on) begin
      n_tests++;
      if (x !== 11'(m_pos % HT) || y !== 10'(m_pos / HT) || de !== m_de ||
          line_start !== m_ls || frame_start !== m_fs ||
          hsync !== m_hs || vsync !== m_vs) begin
        n_fail++;
        if (n_fail <= 10)
          $display("FAIL model_cycle t=%0t got x=%0d y=%0d de=%b ls=%b fs=%b hs=%b vs=%b exp x=%0d y=%0d de=%b ls=%b fs=%b hs=%b vs=%b",
                   $time, x, y, de, line_start, frame_start, hsync, vsync,
                   m_pos % HT, m_pos / HT, m_de, m_ls, m_fs, m_hs, m_vs);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic cyc(input logic e);
    en = e;
    @(posedge clk_in);
    #1;
  endtask

  int de_cnt, hs_cnt, hs_first, vs_cnt, vs_fx, vs_fy, period, px, py;
  bit found;

  initial begin
    rst = 1'b1; en = 1'b0;
    cyc(0); cyc(0);
    chk_on = 1'b1;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_de", de, 0);
    check("rst_ls", line_start, 0);
    check("rst_fs", frame_start, 0);
    check("rst_hs", hsync, 0);
    check("rst_vs", vsync, 0);

    // First enabled cycle presents (0,0).
    rst = 1'b0;
    cyc(1);
    check("first_x", x, 0);
    check("first_y", y, 0);
    check("first_de", de, 1);
    check("first_ls", line_start, 1);
    check("first_fs", frame_start, 1);
    check("first_hs", hsync, 0);

    // One full line.
    de_cnt = int'(de); hs_cnt = 0; hs_first = -1;
    for (int i = 1; i < HT; i++) begin
      cyc(1);
      if (de) de_cnt++;
      if (hsync) begin
        if (hs_cnt == 0) hs_first = int'(x);
        hs_cnt++;
      end
    end
    check("line_de_count", de_cnt, 800);
    check("line_hs_count", hs_cnt, 128);
    check("line_hs_first_x", hs_first, 840);
    cyc(1);
    check("line2_x", x, 0);
    check("line2_y", y, 1);
    check("line2_ls", line_start, 1);
    check("line2_fs", frame_start, 0);

    // Rest of the frame up to the next frame_start.
    period = HT; vs_cnt = 0; vs_fx = -1; vs_fy = -1; found = 0; px = -1; py = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      px = int'(x); py = int'(y);
      cyc(1);
      period++;
      if (vsync) begin
        if (vs_cnt == 0) begin vs_fx = int'(x); vs_fy = int'(y); end
        vs_cnt++;
      end
      if (frame_start) begin found = 1; break; end
    end
    check("frame_found", found, 1);
    check("frame_period", period, 21120);
    check("frame_vs_count", vs_cnt, 4224);
    check("frame_vs_first_x", vs_fx, 0);
    check("frame_vs_first_y", vs_fy, 13);
    check("frame_prev_x", px, 1055);
    check("frame_prev_y", py, 19);
    check("frame_wrap_y", y, 0);
    check("frame_wrap_vs", vsync, 0);

    // Freeze at (799,10).
    for (int i = 0; i < 10 * HT + 799; i++) cyc(1);
    check("pre_hold_x", x, 799);
    check("pre_hold_y", y, 10);
    check("pre_hold_de", de, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0);
      check("hold_x", x, 799);
      check("hold_y", y, 10);
      check("hold_de", de, 0);
    end
    cyc(1);
    check("resume_x", x, 799);
    check("resume_de", de, 1);
    cyc(1);
    check("resume2_x", x, 800);
    check("resume2_de", de, 0);

    // Reset inside both sync pulses at (900,14).
    for (int i = 0; i < 4 * HT + 100; i++) cyc(1);
    check("mid_x", x, 900);
    check("mid_y", y, 14);
    check("mid_hs", hsync, 1);
    check("mid_vs", vsync, 1);
    rst = 1'b1;
    cyc(1);
    check("mrst_x", x, 0);
    check("mrst_y", y, 0);
    check("mrst_de", de, 0);
    check("mrst_hs", hsync, 0);
    check("mrst_vs", vsync, 0);
    rst = 1'b0;
    cyc(1);
    check("post_rst_x", x, 0);
    check("post_rst_y", y, 0);
    check("post_rst_de", de, 1);
    check("post_rst_fs", frame_start, 1);

    // Wrap corner (1055,19) -> (0,0).
    for (int i = 0; i < FRAME - 1; i++) cyc(1);
    check("corner_x", x, 1055);
    check("corner_y", y, 19);
    cyc(1);
    check("wrap_x", x, 0);
    check("wrap_y", y, 0);
    check("wrap_fs", frame_start, 1);
    check("wrap_ls", line_start, 1);
    check("wrap_vs", vsync, 0);

    cyc(0);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
